exc_commit_ctrl: RTL

Sequences precise-exception and ERTN commit after the writeback stage. Captures the stage's exception/ertn submission and issues one-cycle CSR update strobes (ERA, ESTAT, BADV, CRMD/PRMD). Holds the pipeline flush for a fixed number of cycles, then delivers the redirect target to fetch over a valid/ready handshake. Sits between the writeback stage, the CSR file and the fetch stage.

---
 rtl/exc_commit_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: sequences a precise exception or ERTN after writeback.
//   IDLE     - wait for exc_req / ertn_req from writeback (exception wins).
//   COMMIT   - one cycle: CSR update strobes plus the first flush cycle.
//   DRAIN    - flush held until FLUSH_CYCLES flush cycles have elapsed.
//   REDIRECT - target offered to fetch on a valid/ready handshake.
// Ports:
//   clk, resetn                    clock, async active-low reset
//   exc_req, ertn_req              submissions from writeback (sampled in IDLE)
//   ecode, esubcode, exc_pc,
//   exc_maddr                      exception info from writeback
//   csr_eentry, csr_era            current CSR values (redirect targets)
//   busy, flush                    sequence in progress / pipeline flush
//   csr_exc_we, csr_exc_ecode,
//   csr_exc_esubcode, csr_exc_era  exception CSR update strobe + data
//   csr_badv_we, csr_badv          BADV update strobe + data
//   csr_ertn_we                    ERTN CSR update strobe
//   redirect_valid, redirect_pc,
//   redirect_ready                 redirect handshake to fetch
module exc_commit_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [5:0]  ECODE_ADE    = 6'h08,
  parameter logic [5:0]  ECODE_ALE    = 6'h09
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exc_req,
  input  logic        ertn_req,
  input  logic [5:0]  ecode,
  input  logic [8:0]  esubcode,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_maddr,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        busy,
  output logic        flush,
  output logic        csr_exc_we,
  output logic [5:0]  csr_exc_ecode,
  output logic [8:0]  csr_exc_esubcode,
  output logic [31:0] csr_exc_era,
  output logic        csr_badv_we,
  output logic [31:0] csr_badv,
  output logic        csr_ertn_we,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_DRAIN    = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ertn_q, ertn_d;         // 1: ERTN sequence, 0: exception
  logic        badv_q, badv_d;         // BADV write pending for this exception
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esub_q, esub_d;
  logic [31:0] era_q, era_d;
  logic [31:0] badv_val_q, badv_val_d;
  logic [31:0] target_q, target_d;

  logic accept_exc, accept_ertn;

  assign accept_exc  = (state_q == S_IDLE) && exc_req;
  assign accept_ertn = (state_q == S_IDLE) && ertn_req && !exc_req;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ertn_d     = ertn_q;
    badv_d     = badv_q;
    ecode_d    = ecode_q;
    esub_d     = esub_q;
    era_d      = era_q;
    badv_val_d = badv_val_q;
    target_d   = target_q;

    case (state_q)
      S_IDLE: begin
        if (accept_exc) begin
          ecode_d  = ecode;
          esub_d   = esubcode;
          era_d    = exc_pc;
          ertn_d   = 1'b0;
          target_d = csr_eentry;
          // ADEF reports the fetch PC; ADEM and ALE report the data address.
          // Without a BADV write the old value is kept.
          if (ecode == ECODE_ADE && esubcode == 9'd0) begin
            badv_d     = 1'b1;
            badv_val_d = exc_pc;
          end else if (ecode == ECODE_ADE || ecode == ECODE_ALE) begin
            badv_d     = 1'b1;
            badv_val_d = exc_maddr;
          end else begin
            badv_d     = 1'b0;
          end
          state_d = S_COMMIT;
        end else if (accept_ertn) begin
          ertn_d   = 1'b1;
          target_d = csr_era;
          state_d  = S_COMMIT;
        end
      end
      S_COMMIT: begin
        cnt_d   = FLUSH_LOAD;
        state_d = (FLUSH_CYCLES > 1) ? S_DRAIN : S_REDIRECT;
      end
      S_DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ertn_q     <= 1'b0;
      badv_q     <= 1'b0;
      ecode_q    <= '0;
      esub_q     <= '0;
      era_q      <= '0;
      badv_val_q <= '0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ertn_q     <= ertn_d;
      badv_q     <= badv_d;
      ecode_q    <= ecode_d;
      esub_q     <= esub_d;
      era_q      <= era_d;
      badv_val_q <= badv_val_d;
      target_q   <= target_d;
    end
  end

  // Outputs decode from state so reset clears them immediately.
  assign busy             = (state_q != S_IDLE);
  assign flush            = (state_q == S_COMMIT) || (state_q == S_DRAIN);
  assign csr_exc_we       = (state_q == S_COMMIT) && !ertn_q;
  assign csr_badv_we      = (state_q == S_COMMIT) && !ertn_q && badv_q;
  assign csr_ertn_we      = (state_q == S_COMMIT) && ertn_q;
  assign csr_exc_ecode    = ecode_q;
  assign csr_exc_esubcode = esub_q;
  assign csr_exc_era      = era_q;
  assign csr_badv         = badv_val_q;
  assign redirect_valid   = (state_q == S_REDIRECT);
  assign redirect_pc      = (state_q == S_REDIRECT) ? target_q : 32'd0;

endmodule
